if_id_queue: RTL
================

// Module: if_id_queue
// PURPOSE
//   Parametrised IF->ID pipeline stage with a DEPTH-entry instruction queue.
//   - Decouples fetch from decode: IF keeps pushing while ID is stalled, until the queue is full.
//   - Presents one registered {pc, inst} per cycle to ID.
//   - Inserts bubbles when it has nothing to issue; flushes everything on a taken branch from EX.
// PARAMETERS
//   ADDR_W  32  width of pc
//   INST_W  32  width of instruction word
//   DEPTH   4   queue entries; power of 2, >=2
// PORTS
//   clk        in   1                     clock, rising edge
//   rst        in   1                     asynchronous, active-high reset
//   if_pc      in   ADDR_W                pc of the fetched instruction
//   if_inst    in   INST_W                fetched instruction
//   if_valid   in   1                     if_pc/if_inst valid this cycle
//   if_ready   out  1                     queue can accept; = (ifq_count < DEPTH), from registered count only
//   stall      in   6                     pipeline stall vector; [1]=IF stalled, [2]=ID stalled
//   ex_b_flag  in   1                     taken branch/jump resolved in EX; flush
//   id_pc      out  ADDR_W                pc presented to ID (registered)
//   id_inst    out  INST_W                instruction presented to ID (registered)
//   id_valid   out  1                     id_pc/id_inst hold a real instruction (0 = bubble)
//   ifq_count  out  $clog2(DEPTH+1)       current queue occupancy
// BEHAVIOUR
//   Reset (async)
//   - wr_ptr, rd_ptr, ifq_count <= 0.
//   - id_pc, id_inst <= 0; id_valid <= 0.
//   Qualifiers
//   - push = if_valid & if_ready & !stall[1] & !ex_b_flag.
//   Priority per rising edge: ex_b_flag > stall[2] > issue.
//   Flush (ex_b_flag=1)
//   - Pointers and count cleared.
//   - id_pc, id_inst <= 0; id_valid <= 0.
//   - Any incoming instruction is discarded.
//   - Any stall value is overridden.
//   ID stalled (stall[2]=1)
//   - id_* hold their values.
//   - push writes mem[wr_ptr]; wr_ptr++; count++.
//   Issue (stall[2]=0)
//   - count>0: id_* <= mem[rd_ptr]; id_valid <= 1; rd_ptr++.
//     Simultaneous push writes the tail; count is unchanged (net 0), otherwise count--.
//   - count==0 & push: bypass path; see CONFIGURATION.
//   - count==0 & !push: bubble; id_pc, id_inst <= 0; id_valid <= 0.
//     This covers stall[1]&!stall[2]: ID sees a zero bubble.
//   Ordering and wrap
//   - Strict FIFO order.
//   - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
//   Full
//   - if_ready=0 while count==DEPTH, even if a pop occurs that cycle; the push is not taken.
//   - IF must hold if_pc/if_inst until accepted.
//   - ifq_count never exceeds DEPTH and never underflows.
//   Reset mid-operation
//   - All queued entries are lost.
//   - Outputs read 0 asynchronously, without waiting for a clock edge.
// CONFIGURATION
//   IFQ_BYPASS_EN defined
//   - When count==0, push and !stall[2]: id_* <= if_pc/if_inst, id_valid <= 1.
//   - Queue stays empty; IF->ID latency 1 cycle.
//   IFQ_BYPASS_EN undefined
//   - Every instruction is enqueued first.
//   - Empty-queue latency 2 cycles (push cycle, then issue).
//   - The count==0 & push case issues a bubble while enqueuing.
// TESTING
//   1. Defaults, bypass on, no stalls; push pc 0x00,0x04,0x08 on consecutive cycles
//      -> id_pc 0x00,0x04,0x08 one cycle after each; id_valid=1; ifq_count stays 0.
//   2. stall[2]=1 for 6 cycles while IF pushes 0x10,0x14,...
//      -> count reaches 4; if_ready=0; id_* held.
//      Release -> id_pc 0x10,0x14,0x18,0x1C in order, then 0x20 (held by IF).
//   3. count=3; ex_b_flag=1 with a simultaneous push of 0x40
//      -> next edge: count=0, id_inst=0, id_valid=0; 0x40 never appears.
//   4. Queue empty; stall[1]=1, stall[2]=0 -> id_pc=0, id_inst=0, id_valid=0 every cycle.
//   5. Assert rst between edges with count=2 -> outputs and count are 0 immediately;
//      the first post-reset push of 0x80 issues normally.
//   6. Bypass off; single push 0x100 into the empty queue
//      -> bubble on the first edge, id_pc=0x100 with id_valid=1 on the second.

Source files
------------

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue
// Description : IF->ID pipeline stage with a DEPTH-entry instruction queue.
//               Optional empty-queue bypass enabled by macro IFQ_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          if_pc,
    input  logic [INST_W-1:0]          if_inst,
    input  logic                       if_valid,
    output logic                       if_ready,
    input  logic [5:0]                 stall,
    input  logic                       ex_b_flag,
    output logic [ADDR_W-1:0]          id_pc,
    output logic [INST_W-1:0]          id_inst,
    output logic                       id_valid,
    output logic [$clog2(DEPTH+1)-1:0] ifq_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem_pc_q   [DEPTH];
    logic [INST_W-1:0] mem_inst_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;
    logic              id_valid_q, id_valid_d;
    logic              mem_we;
    logic              push;
    logic              unused_stall;

    assign unused_stall = ^{stall[5:3], stall[0]};

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
    assign if_ready = (count_q < C_DEPTH);
    assign push     = if_valid & if_ready & ~stall[1] & ~ex_b_flag;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        mem_we     = 1'b0;

        if (ex_b_flag) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            id_pc_d    = '0;
            id_inst_d  = '0;
            id_valid_d = 1'b0;
        end else if (stall[2]) begin
            if (push) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                count_d  = count_q + CNT_W'(1);
            end
        end else if (count_q != '0) begin
            id_pc_d    = mem_pc_q[rd_ptr_q];
            id_inst_d  = mem_inst_q[rd_ptr_q];
            id_valid_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            if (push) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                count_d  = count_q - CNT_W'(1);
            end
        end else if (push) begin
`ifdef IFQ_BYPASS_EN
            id_pc_d    = if_pc;
            id_inst_d  = if_inst;
            id_valid_d = 1'b1;
`else
            // Enqueue first; ID sees a bubble this cycle and the entry next cycle.
            mem_we     = 1'b1;
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            count_d    = count_q + CNT_W'(1);
            id_pc_d    = '0;
            id_inst_d  = '0;
            id_valid_d = 1'b0;
`endif
        end else begin
            id_pc_d    = '0;
            id_inst_d  = '0;
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
            id_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_pc_q[wr_ptr_q]   <= if_pc;
            mem_inst_q[wr_ptr_q] <= if_inst;
        end
    end

    assign id_pc     = id_pc_q;
    assign id_inst   = id_inst_q;
    assign id_valid  = id_valid_q;
    assign ifq_count = count_q;

endmodule
`default_nettype wire
